// File: rtl/reg_file_pkg.sv
// Shared sizing, write-enable bit positions and data types for the CPU register file.
package reg_file_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NREGS  = 16;
  localparam int unsigned ADDR_W = 4;

  localparam int unsigned WE_P1  = 0;
  localparam int unsigned WE_P2  = 1;
  localparam int unsigned WE_R15 = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t R15_IDX = reg_addr_t'(NREGS - 1);

endpackage

// File: rtl/reg_file_cell.sv
// One register of the file: async active-low clear, next value chosen by write-port priority.
module reg_file_cell
  import reg_file_pkg::*;
#(
  parameter reg_addr_t   IDX    = '0,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        we,
  input  reg_addr_t         addr1,
  input  reg_addr_t         addr2,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data15,
  output logic [DATA_W-1:0] q
);

  logic sel1;
  logic sel2;
  logic sel15;

  // Address compares are gated by the enable so X addresses on idle ports are harmless.
  always_comb begin
    sel1  = 1'b0;
    sel2  = 1'b0;
    sel15 = 1'b0;
    if (we[WE_P1])  sel1  = (addr1 == IDX);
    if (we[WE_P2])  sel2  = (addr2 == IDX);
    if (we[WE_R15]) sel15 = (IDX == R15_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (sel2) begin
      q <= data2;
    end else if (sel1) begin
      q <= data1;
    end else if (sel15) begin
      q <= data15;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 16 x DATA_W register file: two general read ports, a dedicated R15 read port,
// two general write ports plus an R15 write port, and flat per-register observation outputs.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        regWrite,
  input  reg_addr_t         rr1,
  input  reg_addr_t         rr2,
  input  reg_addr_t         wr,
  input  reg_addr_t         wr2,
  input  logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] wd2,
  input  logic [DATA_W-1:0] wd15,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd15,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7,
  output logic [DATA_W-1:0] r8,
  output logic [DATA_W-1:0] r9,
  output logic [DATA_W-1:0] r10,
  output logic [DATA_W-1:0] r11,
  output logic [DATA_W-1:0] r12,
  output logic [DATA_W-1:0] r13,
  output logic [DATA_W-1:0] r14,
  output logic [DATA_W-1:0] r15
);

  logic [DATA_W-1:0] regs [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    reg_file_cell #(
      .IDX    (reg_addr_t'(i)),
      .DATA_W (DATA_W)
    ) u_cell (
      .clk    (clk),
      .rst_n  (reset),
      .we     (regWrite),
      .addr1  (wr),
      .addr2  (wr2),
      .data1  (wd),
      .data2  (wd2),
      .data15 (wd15),
      .q      (regs[i])
    );
  end

  // Reads are straight muxes off the register outputs: no write-through bypass.
  assign rd1  = regs[rr1];
  assign rd2  = regs[rr2];
  assign rd15 = regs[R15_IDX];

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, each write port, collisions, no-bypass, hold and sweep.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  regWrite;
  logic [3:0]  rr1, rr2, wr, wr2;
  logic [15:0] wd, wd2, wd15;
  logic [15:0] rd1, rd2, rd15;
  logic [15:0] r [16];
  logic [15:0] exp_r [16];

  int errors = 0;
  int checks = 0;

  reg_file #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite),
    .rr1(rr1), .rr2(rr2), .wr(wr), .wr2(wr2),
    .wd(wd), .wd2(wd2), .wd15(wd15),
    .rd1(rd1), .rd2(rd2), .rd15(rd15),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]),
    .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s r%0d", tag, i), r[i], exp_r[i]);
    check({tag, " rd15"}, rd15, exp_r[15]);
  endtask

  task automatic write_cycle(input logic [2:0] we, input logic [3:0] a1, input logic [15:0] d1,
                             input logic [3:0] a2, input logic [15:0] d2, input logic [15:0] d15);
    @(negedge clk);
    regWrite = we; wr = a1; wd = d1; wr2 = a2; wd2 = d2; wd15 = d15;
    @(posedge clk);
    #1;
    regWrite = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; regWrite = 3'b000;
    rr1 = 4'd0; rr2 = 4'd0; wr = 4'd0; wr2 = 4'd0;
    wd = '0; wd2 = '0; wd15 = '0;
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset rd1", rd1, 16'h0000);
    check("reset rd2", rd2, 16'h0000);

    @(negedge clk);
    reset = 1'b1;

    // Port 1
    write_cycle(3'b001, 4'd1, 16'hAAAA, 4'd0, 16'h0000, 16'h0000);
    exp_r[1] = 16'hAAAA;
    rr1 = 4'd1; #1;
    check("p1 rd1", rd1, 16'hAAAA);
    check_all("p1");

    // Port 1 plus R15 port
    write_cycle(3'b101, 4'd3, 16'h1234, 4'd0, 16'h0000, 16'hABCD);
    exp_r[3] = 16'h1234; exp_r[15] = 16'hABCD;
    check_all("p1+r15");

    // Port 2 alone, including R0 as a writable register
    write_cycle(3'b010, 4'd0, 16'h0000, 4'd2, 16'hABCD, 16'h0000);
    exp_r[2] = 16'hABCD;
    write_cycle(3'b010, 4'd0, 16'h0000, 4'd0, 16'h0F0F, 16'h0000);
    exp_r[0] = 16'h0F0F;
    check_all("p2");

    // Collisions
    write_cycle(3'b111, 4'd15, 16'h1111, 4'd15, 16'h2222, 16'h3333);
    exp_r[15] = 16'h2222;
    check_all("col all");
    write_cycle(3'b101, 4'd15, 16'h4444, 4'd0, 16'h0000, 16'h5555);
    exp_r[15] = 16'h4444;
    check_all("col p1 r15");
    write_cycle(3'b011, 4'd6, 16'h6666, 4'd6, 16'h7777, 16'h0000);
    exp_r[6] = 16'h7777;
    check_all("col p1 p2");
    write_cycle(3'b111, 4'd7, 16'h7070, 4'd8, 16'h8080, 16'h9999);
    exp_r[7] = 16'h7070; exp_r[8] = 16'h8080; exp_r[15] = 16'h9999;
    check_all("three way");

    // No bypass: old value visible until the edge
    @(negedge clk);
    regWrite = 3'b001; wr = 4'd5; wd = 16'hBEEF; rr2 = 4'd5;
    #1;
    check("nobypass before", rd2, 16'h0000);
    @(posedge clk); #1;
    regWrite = 3'b000;
    check("nobypass after", rd2, 16'hBEEF);
    exp_r[5] = 16'hBEEF;

    // Hold with enables low and garbage on the other inputs
    wr = 4'd9; wr2 = 4'd10; wd = 16'hDEAD; wd2 = 16'hDEAD; wd15 = 16'hDEAD;
    repeat (4) @(posedge clk);
    #1;
    check_all("hold");

    // Reset asserted mid-cycle clears immediately
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) exp_r[i] = 16'h0000;
    rr1 = 4'd1; rr2 = 4'd5; #1;
    check_all("async rst");
    check("async rst rd1", rd1, 16'h0000);
    check("async rst rd2", rd2, 16'h0000);

    // Writes ignored during reset; first write on first edge after release
    regWrite = 3'b001; wr = 4'd4; wd = 16'h4321;
    @(posedge clk); #1;
    check("rst ignores wr", r[4], 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    regWrite = 3'b000;
    exp_r[4] = 16'h4321;
    check_all("rst release");

    // Sweep through port 1, read back on both read ports
    for (int i = 0; i < 16; i++) begin
      write_cycle(3'b001, 4'(i), 16'(i * 16'h1111), 4'd0, 16'h0000, 16'h0000);
      exp_r[i] = 16'(i * 16'h1111);
    end
    for (int i = 0; i < 16; i++) begin
      rr1 = 4'(i); rr2 = 4'(15 - i); #1;
      check($sformatf("sweep rd1 %0d", i), rd1, 16'(i * 16'h1111));
      check($sformatf("sweep rd2 %0d", 15 - i), rd2, 16'((15 - i) * 16'h1111));
    end
    check_all("sweep");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
